// File: rtl/mult_pipe_if.sv
// mult_pipe_if: operand/result handshake bundle for mult_pipe.
// Operand channel: a transfer happens on a rising clk edge where in_valid && in_ready.
// Result channel:  a transfer happens on a rising clk edge where out_valid && out_ready.
// in_valid/operands are ignored while in_ready is low; p_out/sat_out are stable while out_valid && !out_ready.
interface mult_pipe_if #(
    parameter int A_W = 10,
    parameter int B_W = 9,
    parameter int P_W = 19
) ();
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a_in;
    logic [B_W-1:0] b_in;
    logic           signed_in;
    logic [P_W-1:0] p_out;
    logic           sat_out;
    logic           out_valid;
    logic           out_ready;

    // Producer / consumer side (testbench or upstream logic)
    modport master (
        output in_valid, a_in, b_in, signed_in, out_ready,
        input  in_ready, p_out, sat_out, out_valid
    );

    // Multiplier side
    modport slave (
        input  in_valid, a_in, b_in, signed_in, out_ready,
        output in_ready, p_out, sat_out, out_valid
    );
endinterface

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined signed/unsigned multiplier with right shift and saturation.
// The full product is formed, optionally rounded, shifted and saturated in front of
// stage 0; the LAT stages then carry {valid, result, sat} with a global advance enable.
// Optional feature macro: MULT_ROUND_EN (round-half-up before the shift).
module mult_pipe #(
    parameter int A_W   = 10,
    parameter int B_W   = 9,
    parameter int P_W   = 19,
    parameter int SHIFT = 0,
    parameter int LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    mult_pipe_if.slave  bus
);
    localparam int FW = A_W + B_W;
    // Two guard bits: one for the sign of unsigned values, one for the rounding carry.
    localparam int SW = FW + 2;

    localparam logic [SW-1:0] ONE  = SW'(1);
    localparam logic [SW-1:0] SMAX = (ONE << (P_W - 1)) - ONE;
    localparam logic [SW-1:0] SMIN = ~SMAX;
    localparam logic [SW-1:0] UMAX = (ONE << P_W) - ONE;
`ifdef MULT_ROUND_EN
    // Half an output LSB; zero when SHIFT = 0 so rounding is a no-op there.
    localparam logic [SW-1:0] RND  = (ONE << SHIFT) >> 1;
`else
    localparam logic [SW-1:0] RND  = '0;
`endif

    // Reject illegal configurations at elaboration.
    if (A_W < 1 || B_W < 1) begin : g_bad_ab
        $error("mult_pipe: A_W and B_W must be >= 1");
    end
    if (P_W < 1 || P_W > FW) begin : g_bad_pw
        $error("mult_pipe: P_W must be in 1..A_W+B_W");
    end
    if (SHIFT < 0 || SHIFT > FW - 1) begin : g_bad_shift
        $error("mult_pipe: SHIFT must be in 0..A_W+B_W-1");
    end
    if (LAT < 1) begin : g_bad_lat
        $error("mult_pipe: LAT must be >= 1");
    end

    logic [FW-1:0]  w_a_ext;
    logic [FW-1:0]  w_b_ext;
    logic [FW-1:0]  w_f;
    logic [SW-1:0]  w_f_x;
    logic [SW-1:0]  w_r;
    logic [SW-1:0]  w_s;
    logic [P_W-1:0] w_p;
    logic           w_sat;
    logic           w_en;

    logic           r_vld [LAT];
    logic [P_W-1:0] r_p   [LAT];
    logic           r_sat [LAT];

    // The whole pipe moves unless the output holds a result nobody has taken.
    assign w_en         = !r_vld[LAT-1] || bus.out_ready;
    assign bus.in_ready = w_en;

    // Multiply at full width, round, shift and clamp to the output range.
    always_comb begin
        w_a_ext = bus.signed_in ? {{B_W{bus.a_in[A_W-1]}}, bus.a_in} : {{B_W{1'b0}}, bus.a_in};
        w_b_ext = bus.signed_in ? {{A_W{bus.b_in[B_W-1]}}, bus.b_in} : {{A_W{1'b0}}, bus.b_in};
        // Low FW bits of the extended product are exact for both signednesses.
        w_f     = w_a_ext * w_b_ext;
        w_f_x   = {{2{bus.signed_in & w_f[FW-1]}}, w_f};
        w_r     = w_f_x + RND;
        // Unsigned values carry zero guard bits, so the arithmetic shift acts as logical.
        w_s     = $signed(w_r) >>> SHIFT;
        w_p     = w_s[P_W-1:0];
        w_sat   = 1'b0;
        if (bus.signed_in) begin
            if ($signed(w_s) > $signed(SMAX)) begin
                w_p   = SMAX[P_W-1:0];
                w_sat = 1'b1;
            end else if ($signed(w_s) < $signed(SMIN)) begin
                w_p   = SMIN[P_W-1:0];
                w_sat = 1'b1;
            end
        end else if (w_s > UMAX) begin
            w_p   = UMAX[P_W-1:0];
            w_sat = 1'b1;
        end
    end

    // Shift all stages together; data only moves with a valid entry so bubbles keep the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_p[i]   <= '0;
                r_sat[i] <= 1'b0;
            end
        end else if (w_en) begin
            r_vld[0] <= bus.in_valid;
            if (bus.in_valid) begin
                r_p[0]   <= w_p;
                r_sat[0] <= w_sat;
            end
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_p[i]   <= r_p[i-1];
                    r_sat[i] <= r_sat[i-1];
                end
            end
        end
    end

    assign bus.out_valid = r_vld[LAT-1];
    assign bus.p_out     = r_p[LAT-1];
    assign bus.sat_out   = r_sat[LAT-1];
endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed checks of mult_pipe in three configurations
// (defaults, P_W=12, SHIFT=4/LAT=1). Expected values are hand-computed.
module tb_mult_pipe;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [18:0] exp_q[$];

    mult_pipe_if #(.A_W(10), .B_W(9), .P_W(19)) d_if ();
    mult_pipe_if #(.A_W(10), .B_W(9), .P_W(12)) p_if ();
    mult_pipe_if #(.A_W(10), .B_W(9), .P_W(19)) s_if ();

    mult_pipe #(.A_W(10), .B_W(9), .P_W(19), .SHIFT(0), .LAT(3)) u_d (.clk(clk), .rst(rst), .bus(d_if));
    mult_pipe #(.A_W(10), .B_W(9), .P_W(12), .SHIFT(0), .LAT(3)) u_p (.clk(clk), .rst(rst), .bus(p_if));
    mult_pipe #(.A_W(10), .B_W(9), .P_W(19), .SHIFT(4), .LAT(1)) u_s (.clk(clk), .rst(rst), .bus(s_if));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    // Bit pattern of v truncated to w bits.
    function automatic logic [31:0] pat(input int v, input int w);
        logic [31:0] vv;
        logic [31:0] m;
        vv = v;
        m  = (32'd1 << w) - 32'd1;
        return vv & m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Drivers
    task automatic drive_d(input logic v, input logic [9:0] a, input logic [8:0] b, input logic s);
        d_if.in_valid = v; d_if.a_in = a; d_if.b_in = b; d_if.signed_in = s;
    endtask
    task automatic drive_p(input logic v, input logic [9:0] a, input logic [8:0] b, input logic s);
        p_if.in_valid = v; p_if.a_in = a; p_if.b_in = b; p_if.signed_in = s;
    endtask
    task automatic drive_s(input logic v, input logic [9:0] a, input logic [8:0] b, input logic s);
        s_if.in_valid = v; s_if.a_in = a; s_if.b_in = b; s_if.signed_in = s;
    endtask
    task automatic idle_all();
        drive_d(1'b0, 10'd0, 9'd0, 1'b0); d_if.out_ready = 1'b1;
        drive_p(1'b0, 10'd0, 9'd0, 1'b0); p_if.out_ready = 1'b1;
        drive_s(1'b0, 10'd0, 9'd0, 1'b0); s_if.out_ready = 1'b1;
    endtask

    initial begin
        int  sent;
        int  got;
        int  stall_left;
        bit  stalled_once;
        logic [18:0] e;
        logic [18:0] e9;

        rst = 1'b1;
        idle_all();
        nxt();
        nxt();
        // Reset state
        check1("rst_out_valid", d_if.out_valid, 1'b0);
        check("rst_p_out", 32'(d_if.p_out), 32'd0);
        check1("rst_sat_out", d_if.sat_out, 1'b0);
        check1("rst_in_ready", d_if.in_ready, 1'b1);
        check1("rst_s_out_valid", s_if.out_valid, 1'b0);
        rst = 1'b0;
        nxt();

        // 1: unsigned 1023*511 = 522753, visible after edge t+2
        drive_d(1'b1, 10'd1023, 9'd511, 1'b0);
        #1;
        check1("t1_in_ready", d_if.in_ready, 1'b1);
        nxt();
        drive_d(1'b0, 10'd0, 9'd0, 1'b0);
        check1("t1_ov_t", d_if.out_valid, 1'b0);
        nxt();
        check1("t1_ov_t1", d_if.out_valid, 1'b0);
        nxt();
        check1("t1_ov_t2", d_if.out_valid, 1'b1);
        check("t1_p", 32'(d_if.p_out), pat(522753, 19));
        check1("t1_sat", d_if.sat_out, 1'b0);
        nxt();
        check1("t1_ov_after", d_if.out_valid, 1'b0);
        check("t1_p_hold", 32'(d_if.p_out), pat(522753, 19));

        // 2: signed back-to-back: -512*-256 = 131072, -512*255 = -130560
        drive_d(1'b1, 10'(-512), 9'(-256), 1'b1);
        nxt();
        drive_d(1'b1, 10'(-512), 9'd255, 1'b1);
        nxt();
        drive_d(1'b0, 10'd0, 9'd0, 1'b0);
        nxt();
        check1("t2_ov0", d_if.out_valid, 1'b1);
        check("t2_p0", 32'(d_if.p_out), pat(131072, 19));
        check1("t2_sat0", d_if.sat_out, 1'b0);
        nxt();
        check1("t2_ov1", d_if.out_valid, 1'b1);
        check("t2_p1", 32'(d_if.p_out), pat(-130560, 19));
        check1("t2_sat1", d_if.sat_out, 1'b0);
        nxt();
        check1("t2_ov_after", d_if.out_valid, 1'b0);

        // 3: P_W=12 saturation: 100*100 -> 4095 sat, -512*255 -> -2048 sat, 3*-5 -> -15
        drive_p(1'b1, 10'd100, 9'd100, 1'b0);
        nxt();
        drive_p(1'b1, 10'(-512), 9'd255, 1'b1);
        nxt();
        drive_p(1'b1, 10'd3, 9'(-5), 1'b1);
        nxt();
        drive_p(1'b0, 10'd0, 9'd0, 1'b0);
        check1("t3_ov0", p_if.out_valid, 1'b1);
        check("t3_p0", 32'(p_if.p_out), pat(4095, 12));
        check1("t3_sat0", p_if.sat_out, 1'b1);
        nxt();
        check("t3_p1", 32'(p_if.p_out), pat(-2048, 12));
        check1("t3_sat1", p_if.sat_out, 1'b1);
        nxt();
        check("t3_p2", 32'(p_if.p_out), pat(-15, 12));
        check1("t3_sat2", p_if.sat_out, 1'b0);
        nxt();
        check1("t3_ov_after", p_if.out_valid, 1'b0);

        // 4: backpressure, a=1..6, b=2, 4-cycle stall at the first result
        sent = 0; got = 0; stall_left = 0; stalled_once = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (d_if.out_valid && !stalled_once) begin
                stalled_once = 1'b1;
                stall_left   = 4;
            end
            d_if.out_ready = (stall_left == 0);
            drive_d(sent < 6, 10'(sent + 1), 9'd2, 1'b0);
            #1;
            if (stall_left > 0) begin
                check1("t4_stall_in_ready", d_if.in_ready, 1'b0);
                check("t4_stall_p", 32'(d_if.p_out), pat(2, 19));
                stall_left--;
            end
            if (d_if.out_valid && d_if.out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check("t4_data", 32'(d_if.p_out), 32'(e));
                got++;
            end
            if (d_if.in_valid && d_if.in_ready) begin
                exp_q.push_back(19'(2 * (sent + 1)));
                sent++;
            end
            nxt();
        end
        check("t4_count", 32'(got), 32'd6);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        check1("t4_ov_after", d_if.out_valid, 1'b0);
        drive_d(1'b0, 10'd0, 9'd0, 1'b0);
        d_if.out_ready = 1'b1;

        // 5: asynchronous reset with entries in flight
        drive_d(1'b1, 10'd3, 9'd3, 1'b0);
        nxt();
        drive_d(1'b1, 10'd5, 9'd5, 1'b0);
        nxt();
        drive_d(1'b0, 10'd0, 9'd0, 1'b0);
        nxt();
        check1("t5_ov_pre", d_if.out_valid, 1'b1);
        check("t5_p_pre", 32'(d_if.p_out), pat(9, 19));
        #1;
        rst = 1'b1;
        #1;
        check1("t5_ov_rst", d_if.out_valid, 1'b0);
        check("t5_p_rst", 32'(d_if.p_out), 32'd0);
        check1("t5_sat_rst", d_if.sat_out, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check1("t5_in_ready", d_if.in_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            nxt();
            check1("t5_no_stale", d_if.out_valid, 1'b0);
        end

        // 6: SHIFT=4, LAT=1: result registers at the accepting edge
`ifdef MULT_ROUND_EN
        e9 = 19'd1;
`else
        e9 = 19'd0;
`endif
        drive_s(1'b1, 10'd1, 9'd9, 1'b0);
        nxt();
        check1("t6_ov0", s_if.out_valid, 1'b1);
        check("t6_p_1x9", 32'(s_if.p_out), 32'(e9));
        drive_s(1'b1, 10'd1, 9'd7, 1'b0);
        nxt();
        check1("t6_ov1", s_if.out_valid, 1'b1);
        check("t6_p_1x7", 32'(s_if.p_out), 32'd0);
        // -9 >>> 4 = -1; rounded (-9+8) >>> 4 = -1 as well
        drive_s(1'b1, 10'(-1), 9'd9, 1'b1);
        nxt();
        check("t6_p_neg", 32'(s_if.p_out), pat(-1, 19));
        check1("t6_sat_neg", s_if.sat_out, 1'b0);
        drive_s(1'b0, 10'd0, 9'd0, 1'b0);
        nxt();
        check1("t6_ov_after", s_if.out_valid, 1'b0);
        check("t6_p_hold", 32'(s_if.p_out), pat(-1, 19));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
Parametrised, pipelined multiplier with valid/ready handshake. It supports per-transaction signed or unsigned operands, a configurable right-shift of the product, and saturation to the output width. It succeeds the fixed 10x9 single-register multiplier and is used for gain scaling and timing characterisation in the CORDIC datapath.

Parameters:
A_W, 10, width of operand a.
B_W, 9, width of operand b.
P_W, 19, width of p_out; legal range 1..A_W+B_W.
SHIFT, 0, right shift applied to the full product; legal range 0..A_W+B_W-1. Arithmetic shift if signed, logical if unsigned.
LAT, 3, pipeline depth in registers, >=1. This is the accept-to-output latency.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
in_valid  in  1  operand transfer request.
in_ready  out  1  block can accept; combinational.
a_in  in  A_W  operand a.
b_in  in  B_W  operand b.
signed_in  in  1  1: both operands are two's complement; 0: both unsigned.
p_out  out  P_W  shifted, saturated product.
sat_out  out  1  p_out was clamped.
out_valid  out  1  p_out/sat_out hold a valid result.
out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset: all stage valid bits = 0, out_valid = 0, p_out = 0, sat_out = 0. in_ready = 1 while reset is released. Reset mid-operation discards all in-flight entries.
- Arithmetic:
  - F = a_in * b_in at full width A_W+B_W, signed or unsigned per signed_in, which travels with the entry.
  - S = F >> SHIFT.
  - Signed saturation: S is clamped to [-2^(P_W-1), 2^(P_W-1)-1].
  - Unsigned saturation: S is clamped to [0, 2^P_W-1].
  - sat_out = 1 iff clamped.
  - When P_W = A_W+B_W and SHIFT = 0, saturation never fires.
- Pipeline:
  - LAT stages, each holding a valid bit plus data.
  - Global advance enable: en = !out_valid || out_ready.
  - in_ready = en.
  - On a rising edge with en = 1, every stage shifts one position and stage 0 loads {in_valid, operands}.
  - Bubbles are not compressed.
- Latency:
  - A transfer is accepted at edge t when in_valid && in_ready.
  - Its result is presented (out_valid = 1) after edge t+LAT-1.
  - With LAT = 1, the result registers at the accepting edge.
  - Multiply and saturation logic may be placed in any stage; only port timing is specified.
- Output update: p_out and sat_out update only when a valid entry enters the last stage. Otherwise they hold their value, including across bubbles.
- Stall: while out_valid && !out_ready, all stages hold, p_out/sat_out are stable, and in_ready = 0. in_valid is ignored.
- Simultaneous events:
  - out_valid && out_ready && in_valid in the same cycle gives accept and retire on that edge.
  - Full throughput is one result per cycle.
- Ordering: strict FIFO; no entry is lost or duplicated.
- Elaboration: out-of-range parameters stop elaboration with an error.

Optional Feature:
MULT_ROUND_EN.
- Defined: before the shift, 2^(SHIFT-1) is added to F, giving round-half-up; no-op when SHIFT = 0. The addition uses one extra bit, so the rounding carry never wraps, and the result then passes through normal saturation.
- Undefined: plain shift, i.e. truncation toward minus infinity.
- Latency and handshake are identical in both builds.

Test Plan:
1. Defaults, unsigned: a=1023, b=511, signed_in=0, single beat at edge t, out_ready=1 -> out_valid after edge t+2, p_out=522753, sat_out=0, then out_valid=0.
2. Defaults, signed: (a=-512, b=-256) then (a=-512, b=255), back-to-back -> p_out=131072, then -130560, on consecutive cycles; sat_out=0 for both.
3. P_W=12: unsigned 100*100 -> p_out=4095, sat_out=1. Signed -512*255 -> p_out=-2048 (12'h800), sat_out=1. Signed 3*-5 -> p_out=-15, sat_out=0.
4. Backpressure, defaults:
   - Stimulus: stream 6 beats (a=1..6, b=2) with in_valid held high; drop out_ready for 4 cycles at the first out_valid.
   - Response: in_ready=0 while stalled and p_out stable at 2; afterwards 2, 4, 6, 8, 10, 12 in order with none lost.
5. Reset mid-flight: accept 2 beats, assert rst asynchronously between edges -> out_valid, p_out and sat_out drop to 0 immediately; after release no stale result appears, and in_ready=1.
6. SHIFT=4, unsigned, LAT=1:
   - 1*9 -> p_out=0 without MULT_ROUND_EN, 1 with it.
   - 1*7 -> 0 in both builds.
   - Result is visible after the accepting edge.
